// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states, wait-counter width.
package dmem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_R = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // The reserved encoding behaves as a word access whenever it is not rejected.
    function automatic size_e size_norm(input size_e sz);
        return (sz == SZ_R) ? SZ_W : sz;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane mask generation, store-data replication and load extract/extension for one access.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wrep_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    size_e       eff_size_s;
    logic [1:0]  lane_s;
    logic [31:0] shifted_s;

    // Pick the lowest lane of the access; a misaligned offset is truncated down to the access size.
    always_comb begin
        eff_size_s = size_norm(size_e'(size_i));
        lane_s     = 2'b00;
        be_o       = 4'b1111;
        wrep_o     = wdata_i;
        misalign_o = 1'b0;
        case (eff_size_s)
            SZ_B: begin
                lane_s     = off_i;
                be_o       = 4'b0001 << off_i;
                wrep_o     = {4{wdata_i[7:0]}};
                misalign_o = 1'b0;
            end
            SZ_H: begin
                lane_s     = {off_i[1], 1'b0};
                be_o       = off_i[1] ? 4'b1100 : 4'b0011;
                wrep_o     = {2{wdata_i[15:0]}};
                misalign_o = off_i[0];
            end
            default: begin
                lane_s     = 2'b00;
                be_o       = 4'b1111;
                wrep_o     = wdata_i;
                misalign_o = (off_i != 2'b00);
            end
        endcase
    end

    assign shifted_s = rword_i >> {lane_s, 3'b000};

    // Right-aligned load data with sign or zero extension; words pass through untouched.
    always_comb begin
        case (eff_size_s)
            SZ_B:    rdata_o = uns_i ? {24'h000000, shifted_s[7:0]}
                                     : {{24{shifted_s[7]}}, shifted_s[7:0]};
            SZ_H:    rdata_o = uns_i ? {16'h0000, shifted_s[15:0]}
                                     : {{16{shifted_s[15]}}, shifted_s[15:0]};
            default: rdata_o = shifted_s;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, then holds a response until taken.
// Define DMEM_ERR_CHECK_EN to reject misaligned, reserved-size and out-of-range requests.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

`ifdef DMEM_ERR_CHECK_EN
    localparam logic ERR_CHECK = 1'b1;
`else
    localparam logic ERR_CHECK = 1'b0;
`endif
    localparam int               IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0]      DEPTH_L  = 30'(DEPTH_WORDS);
    localparam logic [31:0]      BYTES_L  = 32'(DEPTH_WORDS * 4);
    localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1)
                                                               : {CNT_W{1'b0}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             idle_s;
    logic             op_wr_s;
    logic [31:0]      op_addr_s;
    logic [31:0]      op_wdata_s;
    logic [1:0]       op_size_s;
    logic             op_uns_s;
    logic [29:0]      widx_full_s;
    logic [IDX_W-1:0] widx_s;
    logic [31:0]      rword_s;
    logic [3:0]       be_s;
    logic [31:0]      wrep_s;
    logic [31:0]      rdata_ext_s;
    logic             misalign_s;
    logic             err_s;
    logic             commit_s;
    logic             we_s;

    // With zero wait states the access commits on the accept edge, so it must use the live request.
    assign idle_s     = (state_q == IDLE);
    assign op_wr_s    = idle_s ? req_write    : wr_q;
    assign op_addr_s  = idle_s ? req_addr     : addr_q;
    assign op_wdata_s = idle_s ? req_wdata    : wdata_q;
    assign op_size_s  = idle_s ? req_size     : size_q;
    assign op_uns_s   = idle_s ? req_unsigned : uns_q;

    assign widx_full_s = op_addr_s[31:2] % DEPTH_L;
    assign widx_s      = widx_full_s[IDX_W-1:0];
    assign rword_s     = mem_q[widx_s];

    dmem_lane_align u_lane_align (
        .size_i     (op_size_s),
        .off_i      (op_addr_s[1:0]),
        .uns_i      (op_uns_s),
        .wdata_i    (op_wdata_s),
        .rword_i    (rword_s),
        .be_o       (be_s),
        .wrep_o     (wrep_s),
        .rdata_o    (rdata_ext_s),
        .misalign_o (misalign_s)
    );

    assign err_s = ERR_CHECK & (misalign_s | (op_size_s == SZ_R) | (op_addr_s >= BYTES_L));
    assign we_s  = commit_s & op_wr_s & ~err_s;

    // Next-state, request latch and response computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        commit_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d        = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    req_ready_d = 1'b0;
                    cnt_d       = {CNT_W{1'b0}};
                    if (WAIT_CYCLES == 0) begin
                        state_d      = RESP;
                        commit_s     = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_err_d   = err_s;
                        resp_rdata_d = (op_wr_s || err_s) ? 32'h0000_0000 : rdata_ext_s;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d      = RESP;
                    commit_s     = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_s;
                    resp_rdata_d = (op_wr_s || err_s) ? 32'h0000_0000 : rdata_ext_s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                // ready rises only after the completing cycle, never alongside it
                if (resp_ready) begin
                    state_d      = IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'h0000_0000;
                    resp_err_d   = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d      = IDLE;
                cnt_d        = {CNT_W{1'b0}};
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_rdata_d = 32'h0000_0000;
                resp_err_d   = 1'b0;
            end
        endcase
    end

    // FSM state, latched request and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            wr_q         <= 1'b0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Byte-lane store commit; storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_s && be_s[i]) begin
                mem_q[widx_s][8*i +: 8] <= wrep_s[8*i +: 8];
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance against a byte-array model,
// plus a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int BYTES = DEPTH * 4;
    localparam int WAIT_A = 2;

    logic        clk;
    logic        rst;
    int          tests = 0;
    int          fails = 0;

    logic        a_req_valid, a_req_ready, a_req_write, a_req_unsigned;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [1:0]  a_req_size;
    logic        a_resp_valid, a_resp_ready, a_resp_err;

    logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [1:0]  b_req_size;
    logic        b_resp_valid, b_resp_ready, b_resp_err;

    logic [7:0]  model_mem [BYTES];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_size(a_req_size),
        .req_unsigned(a_req_unsigned), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_size(b_req_size),
        .req_unsigned(b_req_unsigned), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Little-endian byte memory; unchecked builds wrap and truncate, checked builds reject.
    function automatic void model_access(input bit wr, input logic [31:0] ad, input logic [1:0] sz,
                                         input bit uns, input logic [31:0] wd,
                                         output logic [31:0] rd, output bit er);
        int nb;
        int base;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        rd = 32'd0;
`ifdef DMEM_ERR_CHECK_EN
        er   = (sz == 2'd3) || (ad % 32'(nb) != 32'd0) || (ad >= 32'(BYTES));
        base = int'(ad % 32'(BYTES));
`else
        er   = 1'b0;
        base = int'(ad % 32'(BYTES));
        base = base - (base % nb);
`endif
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < nb; i++) model_mem[base + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) rd[8*i +: 8] = model_mem[base + i];
                if (!uns && nb < 4 && rd[8*nb - 1]) begin
                    for (int j = nb; j < 4; j++) rd[8*j +: 8] = 8'hFF;
                end
            end
        end
    endfunction

    // One complete transaction on instance A, starting and ending at a negedge with A idle.
    task automatic xfer_a(input string tag, input bit wr, input logic [31:0] ad, input logic [1:0] sz,
                          input bit uns, input logic [31:0] wd, input int hold,
                          output logic [31:0] obs_rd, output logic obs_er);
        logic [31:0] exp_rd;
        bit          exp_er;
        int          n;
        model_access(wr, ad, sz, uns, wd, exp_rd, exp_er);
        a_resp_ready   = (hold == 0);
        a_req_valid    = 1'b1;
        a_req_write    = wr;
        a_req_addr     = ad;
        a_req_size     = sz;
        a_req_unsigned = uns;
        a_req_wdata    = wd;
        n = 0;
        while (a_req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ":ready"}, {31'd0, a_req_ready}, 32'd1);
        @(negedge clk);
        // junk on the request bus while busy must be ignored
        a_req_valid    = 1'b1;
        a_req_write    = 1'($urandom_range(0, 1));
        a_req_addr     = $urandom;
        a_req_wdata    = $urandom;
        a_req_size     = 2'($urandom_range(0, 3));
        a_req_unsigned = 1'($urandom_range(0, 1));
        n = 1;
        while (a_resp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ":lat"}, 32'(n), 32'(WAIT_A + 1));
        chk({tag, ":rdata"}, a_resp_rdata, exp_rd);
        chk({tag, ":err"}, {31'd0, a_resp_err}, {31'd0, exp_er});
        obs_rd = a_resp_rdata;
        obs_er = a_resp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ":hold_valid"}, {31'd0, a_resp_valid}, 32'd1);
            chk({tag, ":hold_rdata"}, a_resp_rdata, exp_rd);
            chk({tag, ":hold_err"}, {31'd0, a_resp_err}, {31'd0, exp_er});
            chk({tag, ":hold_ready"}, {31'd0, a_req_ready}, 32'd0);
        end
        a_req_valid  = 1'b0;
        a_resp_ready = 1'b1;
        @(negedge clk);
        chk({tag, ":done_valid"}, {31'd0, a_resp_valid}, 32'd0);
        chk({tag, ":done_ready"}, {31'd0, a_req_ready}, 32'd1);
        a_resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] pre;
        bit          pre_er;
        logic [31:0] bd [4];
        logic [31:0] bexp [8];
        int          k;
        int          last;
        int          nresp;

        rst = 1'b0;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 32'd0; a_req_wdata = 32'd0;
        a_req_size = 2'd0; a_req_unsigned = 1'b0; a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'd0; b_req_wdata = 32'd0;
        b_req_size = 2'd0; b_req_unsigned = 1'b0; b_resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
        chk("rst_resp_rdata", a_resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, a_resp_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready_a", {31'd0, a_req_ready}, 32'd1);
        chk("rst_req_ready_b", {31'd0, b_req_ready}, 32'd1);

        for (int w = 0; w < DEPTH; w++) begin
            xfer_a("fill", 1'b1, 32'(w * 4), 2'd2, 1'b0, $urandom, 0, rd, er);
        end

        xfer_a("st_deadbeef", 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, rd, er);
        xfer_a("ld_deadbeef", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, rd, er);
        chk("word_load_value", rd, 32'hDEADBEEF);

        xfer_a("st_byte80", 1'b1, 32'h13, 2'd0, 1'b0, 32'h0000_0080, 0, rd, er);
        xfer_a("ld_sbyte", 1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0, rd, er);
        chk("sbyte_value", rd, 32'hFFFFFF80);
        xfer_a("ld_ubyte", 1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 0, rd, er);
        chk("ubyte_value", rd, 32'h00000080);
        xfer_a("ld_word13", 1'b0, 32'h10, 2'd2, 1'b1, 32'h0, 0, rd, er);
        chk("merged_word_value", rd, 32'h80ADBEEF);

        xfer_a("ld_half11", 1'b0, 32'h11, 2'd1, 1'b0, 32'h0, 0, rd, er);
`ifdef DMEM_ERR_CHECK_EN
        chk("misaligned_half_err", {31'd0, er}, 32'd1);
        chk("misaligned_half_rdata", rd, 32'd0);
`endif
        xfer_a("st_oob", 1'b1, 32'h400, 2'd2, 1'b0, 32'hA5A5_5A5A, 0, rd, er);
`ifdef DMEM_ERR_CHECK_EN
        chk("oob_store_err", {31'd0, er}, 32'd1);
`endif
        xfer_a("ld_addr0", 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0, rd, er);

        xfer_a("backpressure", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5, rd, er);

        // Reset pulse in the middle of a store must drop it without touching storage.
        model_access(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, pre, pre_er);
        a_resp_ready = 1'b1;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h20;
        a_req_wdata = 32'h12345678; a_req_size = 2'd2; a_req_unsigned = 1'b0;
        chk("rstwait_ready", {31'd0, a_req_ready}, 32'd1);
        @(negedge clk);
        a_req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstwait_valid_low", {31'd0, a_resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstwait_no_resp", {31'd0, a_resp_valid}, 32'd0);
        end
        chk("rstwait_ready_back", {31'd0, a_req_ready}, 32'd1);
        a_resp_ready = 1'b0;
        xfer_a("rstwait_load", 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0, rd, er);
        chk("rstwait_preserved", rd, pre);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ad;
            ad = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(BYTES, 1100))
                                             : 32'($urandom_range(0, BYTES - 1));
            xfer_a("rnd", 1'($urandom_range(0, 1)), ad, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2), rd, er);
        end

        // Zero-wait instance: stores then loads, requests offered every cycle.
        for (int i = 0; i < 4; i++) begin
            bd[i]       = $urandom;
            bexp[i]     = 32'd0;
            bexp[i + 4] = bd[i];
        end
        b_resp_ready = 1'b1;
        k = 0; last = -1; nresp = 0;
        for (int cyc = 0; cyc < 30 && nresp < 8; cyc++) begin
            @(negedge clk);
            if (b_resp_valid === 1'b1) begin
                chk("b2b_rdata", b_resp_rdata, bexp[nresp]);
                chk("b2b_err", {31'd0, b_resp_err}, 32'd0);
                if (last >= 0) chk("b2b_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                nresp++;
            end
            if (k < 8) begin
                b_req_valid    = 1'b1;
                b_req_write    = (k < 4);
                b_req_addr     = 32'h40 + 32'(4 * (k % 4));
                b_req_wdata    = bd[k % 4];
                b_req_size     = 2'd2;
                b_req_unsigned = 1'b0;
                if (b_req_ready === 1'b1) k++;
            end else begin
                b_req_valid = 1'b0;
            end
        end
        chk("b2b_count", 32'(nresp), 32'd8);
        b_req_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
